// File: rtl/regfile_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : regfile_pkg                                            |
// | Description : Shared defaults, FSM state type and reset constant for |
// |               the 2-read / 1-write register file with clear engine.  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package regfile_pkg;

    // Default word and address widths (DEPTH = 2**ADDR_W entries).
    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;

    // INIT sweeps zeros through the array; RUN is normal operation.
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_t;

    // Value written by the clear sweep and held on the read ports in reset.
    localparam logic [RF_DATA_W-1:0] RF_ZERO = '0;

endpackage
`default_nettype wire

// File: rtl/regfile_init_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : regfile_init_seq                                       |
// | Description : Post-reset clear sequencer. Walks a pointer over every |
// |               array entry (one per clock) then parks in RUN.         |
// | Ports       : clk, rst (async, active-high)                          |
// |               init_we   - clear write strobe (high throughout INIT)  |
// |               init_addr - entry being cleared this edge             |
// |               ready     - high once every entry has been cleared     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = RF_ADDR_W
)
(
    input  logic              clk,
    input  logic              rst,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic              ready
);

    localparam int unsigned       c_DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(c_DEPTH - 1);

    rf_state_t         r_state;
    rf_state_t         w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        init_we      = 1'b0;
        ready        = 1'b0;
        case (r_state)
            INIT: begin
                init_we    = 1'b1;
                w_ptr_next = r_ptr + ADDR_W'(1);
                // Leave on the edge that clears the last entry rather than
                // waiting for the pointer to wrap.
                if (r_ptr == c_LAST_ADDR) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                ready = 1'b1;
            end
            default: begin
                w_state_next = INIT;
            end
        endcase
    end

    assign init_addr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/regfile_2r1w_init.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : regfile_2r1w_init                                      |
// | Description : Two-read / one-write register file with registered     |
// |               reads, write-first bypass and a post-reset clear sweep.|
// | Ports       : clk, rst (async, active-high)                          |
// |               we, write_addr, write_data - user write port           |
// |               read_addr1/2 -> read_data1/2 (one-cycle latency)       |
// |               ready - array cleared; user writes accepted when high  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module regfile_2r1w_init
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              ready
);

    localparam int unsigned       c_DEPTH = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] c_ZERO  = DATA_W'(RF_ZERO);

    logic              w_init_we;
    logic [ADDR_W-1:0] w_init_addr;
    logic              w_ready;

    logic              w_user_we;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_read_data1;
    logic [DATA_W-1:0] r_read_data2;

    regfile_init_seq #(
        .ADDR_W (ADDR_W)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .init_we   (w_init_we),
        .init_addr (w_init_addr),
        .ready     (w_ready)
    );

    // User writes are dropped (not queued) until the sweep has finished.
    assign w_user_we  = we & w_ready;

    // The clear sweep owns the single write port while it runs.
    assign w_mem_we   = w_init_we | w_user_we;
    assign w_mem_addr = w_init_we ? w_init_addr : write_addr;
    assign w_mem_data = w_init_we ? c_ZERO      : write_data;

    // Array contents are deliberately not reset; the sweep zeroes them.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // Registered read ports. A same-edge write to the addressed entry is
    // forwarded so the port sees the new word (write-first).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_data1 <= c_ZERO;
            r_read_data2 <= c_ZERO;
        end else if (!w_ready) begin
            r_read_data1 <= c_ZERO;
            r_read_data2 <= c_ZERO;
        end else begin
            r_read_data1 <= (w_user_we && (read_addr1 == write_addr)) ? write_data : r_mem[read_addr1];
            r_read_data2 <= (w_user_we && (read_addr2 == write_addr)) ? write_data : r_mem[read_addr2];
        end
    end

    assign read_data1 = r_read_data1;
    assign read_data2 = r_read_data2;
    assign ready      = w_ready;

endmodule
`default_nettype wire
